// File: rtl/fp_sched_pkg.sv
// Shared types for the FP add/sub issue scheduler: the R4 operand bundle,
// requester ids and the IEEE single unpack used on the FADD/FSUB path.
package fp_sched_pkg;

    localparam int FP_FLAGS_W = 5;

    typedef struct packed {
        logic [7:0]  exp;
        logic [46:0] mant;
        logic        sign;
        logic        is_nan;
        logic        is_zero;
    } fp_r4_num_t;

    typedef struct packed {
        fp_r4_num_t  num1;
        logic [31:0] num2;
        logic        add_sub;
        logic [2:0]  rm;
    } fp_r4_op_t;

    typedef enum logic {
        SRC_FMA = 1'b0,
        SRC_ADD = 1'b1
    } src_e;

    // Zero detection is left to the datapath, so is_zero is never asserted here.
    function automatic fp_r4_op_t unpack_ieee(input logic [31:0] n1,
                                              input logic [31:0] n2,
                                              input logic        sub,
                                              input logic [2:0]  rm);
        fp_r4_op_t op;
        op.num1.exp     = n1[30:23];
        op.num1.mant    = {n1[22:0], 24'b0};
        op.num1.sign    = n1[31];
        op.num1.is_nan  = (n1[30:23] == 8'hFF) && (n1[22:0] != 23'd0);
        op.num1.is_zero = 1'b0;
        op.num2         = n2;
        op.add_sub      = sub;
        op.rm           = rm;
        return op;
    endfunction

endpackage

// File: rtl/fp_sched_tracker.sv
// LAT-deep {valid, src, tag} shift register that follows operations through
// the datapath; it advances only while the datapath is enabled.
module fp_sched_tracker
    import fp_sched_pkg::*;
#(
    parameter int LAT  = 3,
    parameter int ID_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            flush,
    input  logic            in_valid,
    input  src_e            in_src,
    input  logic [ID_W-1:0] in_tag,
    output logic            out_valid,
    output src_e            out_src,
    output logic [ID_W-1:0] out_tag,
    output logic            busy
);

    logic [LAT-1:0]           valid_q, valid_d;
    logic [LAT-1:0]           src_q, src_d;
    logic [LAT-1:0][ID_W-1:0] tag_q, tag_d;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        valid_d = valid_q;
        src_d   = src_q;
        tag_d   = tag_q;
        if (en) begin
            valid_d[0] = in_valid;
            src_d[0]   = in_src;
            tag_d[0]   = in_tag;
            for (int i = 1; i < LAT; i++) begin
                valid_d[i] = valid_q[i-1];
                src_d[i]   = src_q[i-1];
                tag_d[i]   = tag_q[i-1];
            end
        end
        // A flush kills in-flight work even while the pipe is stalled.
        if (flush) valid_d = '0;
    end

    // NOTE: non-blocking assignments keep every stage sampling the old value.
    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // NOTE: payload needs no reset; it is meaningless while its valid bit is low.
    always_ff @(posedge clk) begin
        src_q <= src_d;
        tag_q <= tag_d;
    end

    assign out_valid = valid_q[LAT-1];
    assign out_src   = src_e'(src_q[LAT-1]);
    assign out_tag   = tag_q[LAT-1];
    assign busy      = |valid_q;

endmodule

// File: rtl/fp_addsub_sched.sv
// Issue scheduler for the shared FP add/sub datapath: arbitrates FMA addend (A)
// against FADD/FSUB (B). Define FP_SCHED_FMA_PRIO_EN for fixed A-over-B priority.
module fp_addsub_sched
    import fp_sched_pkg::*;
#(
    parameter int LAT  = 3,
    parameter int ID_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  fp_r4_op_t             a_op,
    input  logic [ID_W-1:0]       a_tag,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [31:0]           b_num1,
    input  logic [31:0]           b_num2,
    input  logic                  b_add_sub,
    input  logic [2:0]            b_rm,
    input  logic [ID_W-1:0]       b_tag,
    output logic                  dp_en,
    output logic                  dp_valid,
    output fp_r4_op_t             dp_op,
    input  logic [31:0]           dp_res,
    input  logic [FP_FLAGS_W-1:0] dp_flags,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_src,
    output logic [ID_W-1:0]       res_tag,
    output logic [31:0]           res_data,
    output logic [FP_FLAGS_W-1:0] res_flags,
    output logic                  busy
);

    logic            grant_a, grant_b, issue;
    src_e            grant_src, trk_src;
    logic [ID_W-1:0] issue_tag;

    // A pending result that cannot leave freezes the whole pipe, bubbles included.
    assign dp_en = !(res_valid && !res_ready);

`ifdef FP_SCHED_FMA_PRIO_EN
    always_comb begin
        grant_a = a_valid;
        grant_b = b_valid && !a_valid;
    end
`else
    src_e last_grant_q, last_grant_d;

    always_comb begin
        grant_a = a_valid;
        grant_b = b_valid;
        if (a_valid && b_valid) begin
            grant_a = (last_grant_q == SRC_ADD);
            grant_b = (last_grant_q == SRC_FMA);
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (issue) last_grant_d = grant_src;
    end

    // Starting from B means the first tie after reset goes to A.
    always_ff @(posedge clk) begin
        if (reset) last_grant_q <= SRC_ADD;
        else       last_grant_q <= last_grant_d;
    end
`endif

    assign a_ready   = dp_en && !flush && grant_a;
    assign b_ready   = dp_en && !flush && grant_b;
    assign issue     = (a_valid && a_ready) || (b_valid && b_ready);
    assign dp_valid  = issue;
    assign grant_src = grant_b ? SRC_ADD : SRC_FMA;
    assign issue_tag = grant_b ? b_tag : a_tag;

    always_comb begin
        dp_op = a_op;
        if (grant_b) dp_op = unpack_ieee(b_num1, b_num2, b_add_sub, b_rm);
    end

    fp_sched_tracker #(
        .LAT  (LAT),
        .ID_W (ID_W)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .en        (dp_en),
        .flush     (flush),
        .in_valid  (issue),
        .in_src    (grant_src),
        .in_tag    (issue_tag),
        .out_valid (res_valid),
        .out_src   (trk_src),
        .out_tag   (res_tag),
        .busy      (busy)
    );

    assign res_src   = trk_src;
    assign res_data  = dp_res;
    assign res_flags = dp_flags;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched with a small truncating-adder datapath
// stub and a scoreboard of expected results in issue order.
module tb_fp_addsub_sched;
    import fp_sched_pkg::*;

    localparam int LAT  = 3;
    localparam int ID_W = 5;

    logic                  clk = 1'b0;
    logic                  reset, flush;
    logic                  a_valid, a_ready, b_valid, b_ready;
    fp_r4_op_t             a_op, dp_op;
    logic [ID_W-1:0]       a_tag, b_tag, res_tag;
    logic [31:0]           b_num1, b_num2, dp_res, res_data;
    logic                  b_add_sub;
    logic [2:0]            b_rm;
    logic                  dp_en, dp_valid, res_valid, res_ready, res_src, busy;
    logic [FP_FLAGS_W-1:0] dp_flags, res_flags;

    always #5 clk = ~clk;

    fp_addsub_sched #(.LAT(LAT), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_num1(b_num1), .b_num2(b_num2),
        .b_add_sub(b_add_sub), .b_rm(b_rm), .b_tag(b_tag),
        .dp_en(dp_en), .dp_valid(dp_valid), .dp_op(dp_op),
        .dp_res(dp_res), .dp_flags(dp_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
        .res_tag(res_tag), .res_data(res_data), .res_flags(res_flags), .busy(busy)
    );

    // Positive same-sign add, truncated; exact enough for the directed cases.
    function automatic logic [31:0] fadd_model(input logic [7:0] e1, input logic [22:0] f1,
                                               input logic [31:0] n2);
        logic [7:0]  e2, eb;
        logic [24:0] m1, m2, s;
        e2 = n2[30:23];
        m1 = {2'b01, f1};
        m2 = {2'b01, n2[22:0]};
        if (e1 >= e2) begin eb = e1; m2 = m2 >> (e1 - e2); end
        else          begin eb = e2; m1 = m1 >> (e2 - e1); end
        s = m1 + m2;
        if (s[24]) begin s = s >> 1; eb = eb + 8'd1; end
        return {1'b0, eb, s[22:0]};
    endfunction

    logic [31:0] pipe [LAT];
    always_ff @(posedge clk) begin
        if (dp_en) begin
            pipe[0] <= dp_valid ? fadd_model(dp_op.num1.exp, dp_op.num1.mant[46:24], dp_op.num2) : 32'd0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign dp_res   = pipe[LAT-1];
    assign dp_flags = pipe[LAT-1][4:0] ^ 5'h15;

    typedef struct packed {
        logic                  src;
        logic [ID_W-1:0]       tag;
        logic [31:0]           data;
        logic [FP_FLAGS_W-1:0] flags;
    } exp_t;

    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    logic  prev_stall = 1'b0;
    exp_t  prev_res;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic fp_r4_op_t exp_b_op(input logic [31:0] n1, input logic [31:0] n2,
                                           input logic sub, input logic [2:0] rm);
        fp_r4_op_t op;
        op.num1.exp     = n1[30:23];
        op.num1.mant    = {n1[22:0], 24'd0};
        op.num1.sign    = n1[31];
        op.num1.is_nan  = (n1[30:23] == 8'd255) && (n1[22:0] != 23'd0);
        op.num1.is_zero = 1'b0;
        op.num2 = n2; op.add_sub = sub; op.rm = rm;
        return op;
    endfunction

    function automatic logic [31:0] rand_ieee();
        return {1'b0, 8'(120 + $urandom_range(0, 10)), 23'($urandom)};
    endfunction

    task automatic set_a(input logic [ID_W-1:0] tag);
        a_op.num1.exp     = 8'(120 + $urandom_range(0, 10));
        a_op.num1.mant    = {23'($urandom), 24'($urandom)};
        a_op.num1.sign    = 1'b0;
        a_op.num1.is_nan  = 1'b0;
        a_op.num1.is_zero = 1'b0;
        a_op.num2         = rand_ieee();
        a_op.add_sub      = 1'($urandom);
        a_op.rm           = 3'($urandom);
        a_tag             = tag;
    endtask

    task automatic set_b(input logic [ID_W-1:0] tag, input logic [31:0] n1, input logic [31:0] n2);
        b_num1 = n1; b_num2 = n2; b_tag = tag;
        b_add_sub = 1'b0; b_rm = 3'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
    endtask

    // One clock: drive, sample at negedge against bench expectations, commit at posedge.
    task automatic cyc(input logic av, input logic bv, input logic rr, input logic fl,
                       input logic ear, input logic ebr, input logic erv);
        exp_t e, got;
        a_valid = av; b_valid = bv; res_ready = rr; flush = fl;
        @(negedge clk);
        check("a_ready", a_ready, ear);
        check("b_ready", b_ready, ebr);
        check("dp_valid", dp_valid, ear | ebr);
        check("dp_en", dp_en, !(erv && !rr));
        check("res_valid", res_valid, erv);
        check("busy", busy, sb.size() != 0);
        got = '{res_src, res_tag, res_data, res_flags};
        if (ear) begin
            check("dp_op_a", dp_op, a_op);
            e.src = 1'b0; e.tag = a_tag;
            e.data = fadd_model(a_op.num1.exp, a_op.num1.mant[46:24], a_op.num2);
            e.flags = e.data[4:0] ^ 5'h15;
            sb.push_back(e);
        end else if (ebr) begin
            check("dp_op_b", dp_op, exp_b_op(b_num1, b_num2, b_add_sub, b_rm));
            e.src = 1'b1; e.tag = b_tag;
            e.data = fadd_model(b_num1[30:23], b_num1[22:0], b_num2);
            e.flags = e.data[4:0] ^ 5'h15;
            sb.push_back(e);
        end
        if (prev_stall) check("res_hold", got, prev_res);
        prev_stall = res_valid && !rr;
        prev_res   = got;
        if (res_valid && rr) begin
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result", got, e);
            end
        end
        if (fl) begin sb.delete(); prev_stall = 1'b0; end
        @(posedge clk); #1;
    endtask

    initial begin
        a_op = '0; a_tag = '0; b_tag = '0; b_num1 = '0; b_num2 = '0;
        b_add_sub = 1'b0; b_rm = '0;
        do_reset();
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dp_valid", dp_valid, 1'b0);
        check("rst_dp_en", dp_en, 1'b1);

        // Single B op: 1.0 + 2.0
        set_b(5'd5, 32'h3F80_0000, 32'h4000_0000);
        b_valid = 1'b1; #1;
        check("b_unpack_exp", dp_op.num1.exp, 8'h7F);
        check("b_unpack_mant", dp_op.num1.mant, 47'd0);
        cyc(0, 1, 1, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("res_data_1p2", res_data, 32'h4040_0000);
        check("res_src_b", res_src, 1'b1);
        check("res_tag_b", res_tag, 5'd5);
        cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);

        // NaN operand on the B path
        set_b(5'd7, 32'h7FC0_0001, rand_ieee());
        cyc(0, 1, 1, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1);

        // Tie after reset: A, B, A, B
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_a(5'(10 + i));
            set_b(5'(20 + i), rand_ieee(), rand_ieee());
            cyc(1, 1, 1, 0, (i % 2) == 0, (i % 2) == 1, i == 3);
        end
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);

        // Back-pressure
        for (int i = 0; i < 3; i++) begin
            set_b(5'(i), rand_ieee(), rand_ieee());
            cyc(0, 1, 1, 0, 0, 1, 0);
        end
        set_b(5'd3, rand_ieee(), rand_ieee());
        set_a(5'd30);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 1, 1);
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);

        // Flush with three A ops in flight
        for (int i = 0; i < 3; i++) begin
            set_a(5'(12 + i));
            cyc(1, 0, 1, 0, 1, 0, 0);
        end
        set_a(5'd15);
        cyc(1, 0, 1, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);

        // Sustained tie: fixed priority or round-robin
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_a(5'(i + 1));
            set_b(5'(i + 17), rand_ieee(), rand_ieee());
`ifdef FP_SCHED_FMA_PRIO_EN
            cyc(1, 1, 1, 0, 1, 0, i >= 3);
`else
            cyc(1, 1, 1, 0, (i % 2) == 0, (i % 2) == 1, i >= 3);
`endif
        end
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);

        // Reset with two ops in flight
        for (int i = 0; i < 2; i++) begin
            set_b(5'(i + 8), rand_ieee(), rand_ieee());
            cyc(0, 1, 1, 0, 0, 1, 0);
        end
        do_reset();
        check("mid_rst_res_valid", res_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        set_a(5'd25);
        set_b(5'd26, rand_ieee(), rand_ieee());
        cyc(1, 1, 1, 0, 1, 0, 0);
        repeat (2) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_addsub_sched.md
# fp_addsub_sched

Issue scheduler for the shared FP add/sub datapath built around the R4 extract/align stage. It arbitrates between the FMA post-multiply addend path (requester A) and plain FADD/FSUB (requester B), drives the LAT-stage datapath, and tracks in-flight operations so each result returns with its source and tag. The block sits between the FP decode/issue logic and the FP writeback port.

## Interface
- `LAT`, 3: datapath pipeline depth in enabled cycles, ≥1.
- `ID_W`, 5: tag width (destination register id).

One clock; reset is synchronous and active-high.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: kill all in-flight operations.
- `a_valid` in 1, `a_ready` out 1: FMA requester handshake.
- `a_op` in `fp_r4_op_t`: unpacked num1 (exp[7:0], mant[46:0], sign, is_nan, is_zero), num2[31:0], add_sub, rm[2:0].
- `a_tag` in ID_W: FMA tag.
- `b_valid` in 1, `b_ready` out 1: FADD/FSUB requester handshake.
- `b_num1` in 32, `b_num2` in 32: IEEE single operands.
- `b_add_sub` in 1: 1 = subtract.
- `b_rm` in 3: rounding mode.
- `b_tag` in ID_W: FADD/FSUB tag.
- `dp_en` out 1: global datapath stage enable.
- `dp_valid` out 1: issue this cycle.
- `dp_op` out `fp_r4_op_t`: datapath operand bundle.
- `dp_res` in 32, `dp_flags` in 5: datapath output stage (NV,DZ,OF,UF,NX).
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_src` out 1: 0 = A, 1 = B.
- `res_tag` out ID_W; `res_data` out 32; `res_flags` out 5: result fields, wired from the tracker and `dp_res`/`dp_flags`.
- `busy` out 1: any operation in flight.

## Operation
- **Tracker.** LAT-entry shift register of {valid, src, tag}. Entry 0 is loaded with the issue; the register shifts only when `dp_en`=1.
  - `res_valid` = entry[LAT-1].valid.
  - `busy` = OR of all valid bits.
- **Stall.** `dp_en` = !(res_valid && !res_ready). The whole pipe freezes on stall, bubbles included; bubbles are not collapsed.
- **Grant.**
  - Only one valid requester: it wins.
  - Both valid: round-robin on the `last_grant` register. The requester not granted last wins.
  - `last_grant` updates only on an accepted issue.
- **Readies.** `a_ready` = dp_en && !flush && grant==A. `b_ready` likewise for B. Issue is the accepted handshake, and `dp_valid` = issue.
- **`dp_op` mux.** Combinational.
  - A: `a_op` passed through.
  - B: exp=b_num1[30:23]; mant={b_num1[22:0],24'b0}; sign=b_num1[31]; is_nan=(exp==8'hFF && b_num1[22:0]!=0); is_zero=0 (the datapath detects zero itself); num2, add_sub, rm from the B ports.
- **Flush.** All valid bits clear at the next edge. Flush blocks any issue in its cycle (flush wins over issue). `res_valid` is not gated by flush in the flush cycle itself.
- **Reset.**
  - Clears all tracker valid bits and sets `last_grant`=B, so the first tie goes to A.
  - Outputs after reset: res_valid=0, busy=0, dp_valid=0, dp_en=1, a_ready/b_ready follow the inputs.
  - Reset mid-operation discards in-flight work without producing a result.

## Timing
- Issue accepted at an enabled edge → result presented after exactly LAT enabled edges, with `res_tag`/`res_src` aligned to `dp_res`.
- With no stall, throughput is one issue per cycle and latency is LAT cycles.
- Stall holds all `res_*` stable until `res_ready`. A result and a new issue complete in the same cycle whenever `res_ready`=1.

## Configuration
- `FP_SCHED_FMA_PRIO_EN` defined: fixed priority, A always beats B. `last_grant` is unused and B may starve.
- Undefined: round-robin as described in Operation.

## Structure
- **Package `fp_sched_pkg`:** `fp_r4_op_t` packed struct (94 bits), `src_e` enum {SRC_FMA=0, SRC_ADD=1}, `FP_FLAGS_W`=5.
- **Sub-module `fp_sched_tracker`:** LAT-deep {valid, src, tag} shift register with enable, flush and reset. Arbitration, the B unpack mux and handshake logic stay in the top module.

## Test plan
- **Single B op.** Only B valid with b_num1=0x3F800000, b_num2=0x40000000, add → b_ready=1; dp_op.exp=0x7F, mant=0; res_valid 3 cycles later with res_src=1, tag echoed, res_data=0x40400000.
- **Tie after reset.** a_valid=b_valid=1 held 4 cycles → grants A,B,A,B; results return in that order with matching tags.
- **Back-pressure.** res_ready=0 for 2 cycles while res_valid → dp_en=0, a_ready=b_ready=0, res_* stable; on release, the following results still arrive at 1/cycle.
- **Flush.** 3 ops in flight plus flush with a_valid=1 → a_ready=0 that cycle; busy=0 and no res_valid next cycle.
- **Fixed priority.** With `FP_SCHED_FMA_PRIO_EN`, a_valid and b_valid held 5 cycles → A granted all 5, b_ready=0 throughout.
- **Reset mid-operation.** reset pulsed with 2 ops in flight → res_valid=0, busy=0 after the edge; next tie grants A.
